dmem_responder: RTL and testbench

- Data-memory responder on the MEM-stage side of the pipeline. It is the far end of the pipeline's load/store request interface.
- Accepts word reads and writes and serves them from a direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
- Backs the cache with an internal word-array main store that has a fixed access latency.
- Raises mem_stall so the pipeline freezes until the access completes.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_tag_array.sv | 45 ++++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types, default geometry and address-field helpers for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  localparam int unsigned NUM_LINES_DFLT = 16;
  localparam int unsigned MEM_WORDS_DFLT = 256;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES_DFLT);
  localparam int unsigned WIDX_W = $clog2(MEM_WORDS_DFLT);
  localparam int unsigned TAG_W  = WIDX_W - IDX_W;

  // Word index of a byte address; callers truncate to the store size so indices wrap.
  function automatic logic [31:0] addr_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Everything above the line index; caller truncates to its tag width.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dmem_tag_array.sv
// Direct-mapped, one-word-per-line storage with a combinational lookup and a single fill/update port.
module dmem_tag_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LINE_IDX_W = IDX_W,
  parameter int unsigned LINE_TAG_W = TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_IDX_W-1:0] lk_idx,
  input  logic [LINE_TAG_W-1:0] lk_tag,
  output logic                  lk_hit,
  output logic [31:0]           lk_data,
  input  logic                  wr_en,
  input  logic [LINE_IDX_W-1:0] wr_idx,
  input  logic [LINE_TAG_W-1:0] wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int unsigned LINES = 1 << LINE_IDX_W;

  logic [LINES-1:0]      valid;
  logic [LINE_TAG_W-1:0] tags  [LINES];
  logic [31:0]           words [LINES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; a write under reset is dropped so an aborted access leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign lk_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_data = words[lk_idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: write-through, no-write-allocate direct-mapped cache
// in front of a fixed-latency word store, stalling the pipeline until each access completes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned NUM_LINES    = NUM_LINES_DFLT,
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DFLT,
  parameter int unsigned MISS_LATENCY = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      req_addr,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      resp_rdata,
  output logic             hit,
  output logic             mem_stall,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned LINE_IDX_W = $clog2(NUM_LINES);
  localparam int unsigned WORD_IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned LINE_TAG_W = WORD_IDX_W - LINE_IDX_W;
  localparam int unsigned WAIT_W     = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MISS_LATENCY - 1);

  state_e                state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WORD_IDX_W-1:0] lat_widx;
  logic [31:0]           lat_wdata;

  logic [WORD_IDX_W-1:0] req_widx;
  logic [LINE_IDX_W-1:0] req_idx, lat_idx, lk_idx;
  logic [LINE_TAG_W-1:0] req_tag, lat_tag, lk_tag;
  logic                  lk_hit;
  logic [31:0]           lk_data;
  logic                  fill_en;
  logic [31:0]           fill_data;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic [31:0]           mem [MEM_WORDS];

  assign req_widx = WORD_IDX_W'(addr_word(req_addr));
  assign req_idx  = LINE_IDX_W'(addr_index(req_addr, LINE_IDX_W));
  assign req_tag  = LINE_TAG_W'(addr_tag(req_addr, LINE_IDX_W));
  assign lat_idx  = lat_widx[LINE_IDX_W-1:0];
  assign lat_tag  = lat_widx[WORD_IDX_W-1:LINE_IDX_W];

  // Live request is looked up in IDLE; the latched store address is looked up while it commits.
  assign lk_idx = (state == IDLE) ? req_idx : lat_idx;
  assign lk_tag = (state == IDLE) ? req_tag : lat_tag;

  dmem_tag_array #(
    .LINE_IDX_W (LINE_IDX_W),
    .LINE_TAG_W (LINE_TAG_W)
  ) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_idx  (lk_idx),
    .lk_tag  (lk_tag),
    .lk_hit  (lk_hit),
    .lk_data (lk_data),
    .wr_en   (fill_en),
    .wr_idx  (lat_idx),
    .wr_tag  (lat_tag),
    .wr_data (fill_data)
  );

  // Backing store is never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[lat_widx] <= lat_wdata;
    end
  end

  assign mem_rdata = mem[lat_widx];

  always_comb begin
    mem_stall  = 1'b0;
    hit        = 1'b0;
    resp_rdata = '0;
    fill_en    = 1'b0;
    fill_data  = mem_rdata;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_wr) begin
          mem_stall = 1'b1;
        end else if (req_rd) begin
          if (lk_hit) begin
            hit        = 1'b1;
            resp_rdata = lk_data;
          end else begin
            mem_stall = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt != '0) begin
          mem_stall = 1'b1;
        end else begin
          resp_rdata = mem_rdata;
          fill_en    = 1'b1;
        end
      end
      WR_WAIT: begin
        if (wait_cnt != '0) begin
          mem_stall = 1'b1;
        end else begin
          mem_we    = 1'b1;
          fill_en   = lk_hit;
          fill_data = lat_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_widx  <= '0;
      lat_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_wr) begin
            lat_widx  <= req_widx;
            lat_wdata <= req_wdata;
            wait_cnt  <= WAIT_INIT;
            state     <= WR_WAIT;
          end else if (req_rd) begin
            if (lk_hit) begin
              hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
            end else begin
              lat_widx <= req_widx;
              wait_cnt <= WAIT_INIT;
              miss_cnt <= (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;
              state    <= RD_WAIT;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven scoreboard bench for dmem_responder with a small cache/memory reference model.
module tb_dmem_responder;

  localparam int unsigned NL = 16;
  localparam int unsigned MW = 256;
  localparam int unsigned ML = 4;
  localparam int unsigned CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   req_addr;
  logic          req_rd;
  logic          req_wr;
  logic [31:0]   req_wdata;
  logic [31:0]   resp_rdata;
  logic          hit;
  logic          mem_stall;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  always #5 clk = ~clk;

  dmem_responder #(
    .NUM_LINES    (NL),
    .MEM_WORDS    (MW),
    .MISS_LATENCY (ML),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_wdata  (req_wdata),
    .resp_rdata (resp_rdata),
    .hit        (hit),
    .mem_stall  (mem_stall),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          perturb;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mmem [MW];
  bit          mvalid [NL];
  int          mtag [NL];
  int          mhit;
  int          mmiss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NL); i++) mvalid[i] = 1'b0;
    mhit  = 0;
    mmiss = 0;
  endtask

  // Reference model: update cache/memory state and queue what the DUT must return.
  task automatic model_push(input vec_t v);
    exp_t e;
    int   w, ix, tg;
    w  = int'((v.addr >> 2) & (MW - 1));
    ix = w % int'(NL);
    tg = w / int'(NL);
    if (v.wr) begin
      mmem[w]  = v.wdata;
      e.data   = 32'd0;
      e.hit    = 1'b0;
      e.stalls = int'(ML);
    end else begin
      e.data = mmem[w];
      if (mvalid[ix] && mtag[ix] == tg) begin
        e.hit    = 1'b1;
        e.stalls = 0;
        if (mhit < CNT_MAX) mhit++;
      end else begin
        e.hit      = 1'b0;
        e.stalls   = int'(ML);
        mvalid[ix] = 1'b1;
        mtag[ix]   = tg;
        if (mmiss < CNT_MAX) mmiss++;
      end
    end
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the completing edge, request still driven.
  task automatic access(input vec_t v, input string name);
    exp_t e;
    int   st;
    bit   done;
    req_rd    = v.rd;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    model_push(v);
    st   = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) begin
        st++;
        @(posedge clk);
        #1;
        if (v.perturb) begin
          req_addr  = v.addr ^ 32'h0000_0080;
          req_wdata = ~v.wdata;
        end
      end else begin
        done = 1'b1;
      end
    end
    e = sb.pop_front();
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " stalls"}, 32'(st), 32'(e.stalls));
    check({name, " rdata"}, resp_rdata, e.data);
    check({name, " hit"}, 32'(hit), 32'(e.hit));
    @(posedge clk);
    #1;
    check({name, " hit_cnt"}, 32'(hit_cnt), 32'(mhit));
    check({name, " miss_cnt"}, 32'(miss_cnt), 32'(mmiss));
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  task automatic idle();
    req_rd = 1'b0;
    req_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Start an access, let it reach the wait state, then reset with requests dropped.
  task automatic abort_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input string name);
    req_rd    = !wr;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check({name, " stall before reset"}, 32'(mem_stall), 32'd1);
    rst_n  = 1'b0;
    req_rd = 1'b0;
    req_wr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check({name, " stall after reset"}, 32'(mem_stall), 32'd0);
    check({name, " hit_cnt after reset"}, 32'(hit_cnt), 32'd0);
    check({name, " miss_cnt after reset"}, 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t pre [4];
  vec_t tbl [16];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pre[0] = '{0, 1, 32'h0000_0040, 32'h1111_0040, 0};
    pre[1] = '{0, 1, 32'h0000_0080, 32'h2222_0080, 0};
    pre[2] = '{0, 1, 32'h0000_0100, 32'h3333_0100, 0};
    pre[3] = '{0, 1, 32'h0000_0044, 32'h4444_0044, 0};

    tbl[0]  = '{1, 0, 32'h0000_0040, 32'h0,         0};  // cold miss
    tbl[1]  = '{1, 0, 32'h0000_0040, 32'h0,         0};  // hit
    tbl[2]  = '{0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 1};  // write hit, inputs wander
    tbl[3]  = '{1, 0, 32'h0000_0040, 32'h0,         0};
    tbl[4]  = '{0, 1, 32'h0000_0080, 32'hCAFE_0080, 0};  // write miss, no allocate
    tbl[5]  = '{1, 0, 32'h0000_0080, 32'h0,         1};
    tbl[6]  = '{1, 0, 32'h0000_0040, 32'h0,         0};  // conflict chain
    tbl[7]  = '{1, 0, 32'h0000_0080, 32'h0,         0};
    tbl[8]  = '{1, 0, 32'h0000_0040, 32'h0,         0};
    tbl[9]  = '{1, 1, 32'h0000_0044, 32'hABCD_0044, 0};  // write wins
    tbl[10] = '{1, 0, 32'h0000_0044, 32'h0,         0};
    tbl[11] = '{1, 0, 32'h0000_0044, 32'h0,         0};
    tbl[12] = '{1, 0, 32'h0000_0440, 32'h0,         0};  // wraps onto word 16
    tbl[13] = '{1, 0, 32'h0000_0043, 32'h0,         0};  // offset ignored
    tbl[14] = '{0, 1, 32'h0000_0444, 32'h5A5A_5A5A, 0};  // wraps onto resident 0x44
    tbl[15] = '{1, 0, 32'h0000_0044, 32'h0,         0};

    rst_n     = 1'b0;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (pre[i]) begin
      access(pre[i], $sformatf("pre%0d", i));
      idle();
    end

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset hit_cnt", 32'(hit_cnt), 32'd0);
    check("reset miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      access(tbl[i], $sformatf("vec%0d", i));
      idle();
    end

    // Back-to-back: no idle cycle between requests; also drives hit_cnt into saturation.
    access('{0, 1, 32'h0000_0048, 32'h0BAD_0048, 0}, "b2b wr");
    access('{1, 0, 32'h0000_0048, 32'h0, 0}, "b2b rd miss");
    for (int i = 0; i < 4; i++) access('{1, 0, 32'h0000_0048, 32'h0, 0}, $sformatf("b2b hit%0d", i));
    idle();

    abort_access(1'b0, 32'h0000_0100, 32'h0, "abort rd");
    access('{1, 0, 32'h0000_0100, 32'h0, 0}, "post-abort rd");
    idle();

    abort_access(1'b1, 32'h0000_0044, 32'h7777_7777, "abort wr");
    access('{1, 0, 32'h0000_0044, 32'h0, 0}, "post-abort wr rd");
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
